fp_div_special_case_unit: RTL and testbench

Parametrised, two-stage pipelined front end for the floating-point non-restoring divider. It classifies both operands of an A/B divide and resolves IEEE-754 special cases directly: NaN, infinity, zero and divide-by-zero. It forwards operands that need iteration to the divider core as hidden-bit significands plus a biased exponent difference. It keeps sticky invalid and divide-by-zero flags.

---
 rtl/fp_div_special_case_unit.sv | 194 +++++++++++++++++++
 tb/tb_fp_div_special_case_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_special_case_unit.sv
// Two-stage classify/resolve front end for the FP non-restoring divider (A/B).
// Optional build macro: SUBNORMAL_FLUSH_EN flushes subnormal operands to a zero of the same sign.
module fp_div_special_case_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MAN_W:0]    in_a,
  input  logic [EXP_W+MAN_W:0]    in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_class_a,
  output logic [4:0]              out_class_b,
  output logic                    out_special,
  output logic [EXP_W+MAN_W:0]    out_result,
  output logic                    out_sign,
  output logic [MAN_W:0]          out_man_a,
  output logic [MAN_W:0]          out_man_b,
  output logic signed [EXP_W+1:0] out_exp_diff,
  output logic                    out_invalid,
  output logic                    out_divzero,
  input  logic                    clr_flags,
  output logic                    flag_invalid,
  output logic                    flag_divzero
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [4:0] CLS_INF  = 5'b10000;
  localparam logic [4:0] CLS_ZERO = 5'b01000;
  localparam logic [4:0] CLS_NAN  = 5'b00100;
  localparam logic [4:0] CLS_SUB  = 5'b00010;
  localparam logic [4:0] CLS_NORM = 5'b00001;

  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [4:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    if (&e) begin
      classify = (m == '0) ? CLS_INF : CLS_NAN;
    end else if (e == '0) begin
`ifdef SUBNORMAL_FLUSH_EN
      classify = CLS_ZERO;
`else
      classify = (m == '0) ? CLS_ZERO : CLS_SUB;
`endif
    end else begin
      classify = CLS_NORM;
    end
  endfunction

  // Zero class (true or flushed) forwards an all-zero significand.
  function automatic logic [MAN_W:0] significand(input logic [W-1:0] x, input logic [4:0] cls);
    if (cls[3]) significand = '0;
    else        significand = {(x[W-2:MAN_W] != '0), x[MAN_W-1:0]};
  endfunction

  function automatic logic signed [EXP_W+1:0] exp_eff(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0) exp_eff = (EXP_W+2)'(1);
    else                    exp_eff = $signed({2'b00, x[W-2:MAN_W]});
  endfunction

  logic adv_p2;

  // ---- stage 1: operand and class registers
  logic           vld_p1;
  logic [W-1:0]   a_p1;
  logic [W-1:0]   b_p1;
  logic [4:0]     cls_a_p1;
  logic [4:0]     cls_b_p1;

  assign adv_p2   = !out_valid || out_ready;
  assign in_ready = !vld_p1 || adv_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1     <= in_a;
      b_p1     <= in_b;
      cls_a_p1 <= classify(in_a);
      cls_b_p1 <= classify(in_b);
    end
  end

  // ---- stage 2: special-case resolution (combinational from stage 1)
  logic                    a_inf, a_zero, a_nan;
  logic                    b_inf, b_zero, b_nan;
  logic                    sign_c;
  logic                    snan_c;
  logic                    special_c;
  logic [W-1:0]            result_c;
  logic                    invalid_c;
  logic                    divzero_c;
  logic signed [EXP_W+1:0] exp_diff_c;

  assign a_inf  = cls_a_p1[4];
  assign a_zero = cls_a_p1[3];
  assign a_nan  = cls_a_p1[2];
  assign b_inf  = cls_b_p1[4];
  assign b_zero = cls_b_p1[3];
  assign b_nan  = cls_b_p1[2];
  assign sign_c = a_p1[W-1] ^ b_p1[W-1];
  assign snan_c = (a_nan && !a_p1[MAN_W-1]) || (b_nan && !b_p1[MAN_W-1]);
  assign exp_diff_c = exp_eff(a_p1) - exp_eff(b_p1) + BIAS;

  // Priority chain: NaN, invalid forms, inf/x, x/inf, divide-by-zero, zero/x.
  always_comb begin
    special_c = 1'b0;
    result_c  = '0;
    invalid_c = 1'b0;
    divzero_c = 1'b0;
    if (a_nan || b_nan) begin
      special_c = 1'b1;
      result_c  = QNAN;
      invalid_c = snan_c;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      special_c = 1'b1;
      result_c  = QNAN;
      invalid_c = 1'b1;
    end else if (a_inf) begin
      special_c = 1'b1;
      result_c  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      special_c = 1'b1;
      result_c  = {sign_c, {(W-1){1'b0}}};
    end else if (b_zero) begin
      special_c = 1'b1;
      result_c  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      divzero_c = 1'b1;
    end else if (a_zero) begin
      special_c = 1'b1;
      result_c  = {sign_c, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_class_a  <= '0;
      out_class_b  <= '0;
      out_special  <= 1'b0;
      out_result   <= '0;
      out_sign     <= 1'b0;
      out_man_a    <= '0;
      out_man_b    <= '0;
      out_exp_diff <= '0;
      out_invalid  <= 1'b0;
      out_divzero  <= 1'b0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_class_a  <= cls_a_p1;
        out_class_b  <= cls_b_p1;
        out_special  <= special_c;
        out_result   <= result_c;
        out_sign     <= sign_c;
        out_man_a    <= significand(a_p1, cls_a_p1);
        out_man_b    <= significand(b_p1, cls_b_p1);
        out_exp_diff <= exp_diff_c;
        out_invalid  <= invalid_c;
        out_divzero  <= divzero_c;
      end
    end
  end

  // Sticky flags: a setting transfer overrides a same-cycle clear.
  logic xfer;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_invalid <= 1'b0;
      flag_divzero <= 1'b0;
    end else begin
      flag_invalid <= (flag_invalid && !clr_flags) || (xfer && out_invalid);
      flag_divzero <= (flag_divzero && !clr_flags) || (xfer && out_divzero);
    end
  end

endmodule

// File: tb/tb_fp_div_special_case_unit.sv
// Randomised and directed bench for fp_div_special_case_unit with an in-bench reference model.
module tb_fp_div_special_case_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class_a;
  logic [4:0]  out_class_b;
  logic        out_special;
  logic [31:0] out_result;
  logic        out_sign;
  logic [23:0] out_man_a;
  logic [23:0] out_man_b;
  logic signed [9:0] out_exp_diff;
  logic        out_invalid;
  logic        out_divzero;
  logic        clr_flags;
  logic        flag_invalid;
  logic        flag_divzero;

  fp_div_special_case_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class_a(out_class_a), .out_class_b(out_class_b),
    .out_special(out_special), .out_result(out_result), .out_sign(out_sign),
    .out_man_a(out_man_a), .out_man_b(out_man_b), .out_exp_diff(out_exp_diff),
    .out_invalid(out_invalid), .out_divzero(out_divzero),
    .clr_flags(clr_flags), .flag_invalid(flag_invalid), .flag_divzero(flag_divzero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  cls_a;
    logic [4:0]  cls_b;
    logic        special;
    logic [31:0] result;
    logic        sign;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [9:0]  exp_diff;
    logic        invalid;
    logic        divzero;
  } res_t;

  int checks = 0;
  int errors = 0;
  res_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: IEEE-754 single decode and the divide special-case rules.
  function automatic logic [4:0] cls_of(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? 5'b10000 : 5'b00100;
    if (x[30:23] == 8'h00) begin
      if (x[22:0] == 0) return 5'b01000;
`ifdef SUBNORMAL_FLUSH_EN
      return 5'b01000;
`else
      return 5'b00010;
`endif
    end
    return 5'b00001;
  endfunction

  function automatic int eeff(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    return (e == 0) ? 1 : e;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    int d;
    bit a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s;
    r = '0;
    r.cls_a = cls_of(a);
    r.cls_b = cls_of(b);
    s = a[31] ^ b[31];
    r.sign = s;
    a_nan = (r.cls_a == 5'b00100); a_inf = (r.cls_a == 5'b10000); a_zero = (r.cls_a == 5'b01000);
    b_nan = (r.cls_b == 5'b00100); b_inf = (r.cls_b == 5'b10000); b_zero = (r.cls_b == 5'b01000);
    r.man_a = a_zero ? 24'h0 : (((a[30:23] != 0) ? 24'h800000 : 24'h0) + {1'b0, a[22:0]});
    r.man_b = b_zero ? 24'h0 : (((b[30:23] != 0) ? 24'h800000 : 24'h0) + {1'b0, b[22:0]});
    d = eeff(a) - eeff(b) + 127;
    r.exp_diff = d[9:0];
    if (a_nan || b_nan) begin
      r.special = 1; r.result = 32'h7FC00000;
      r.invalid = (a_nan && !a[22]) || (b_nan && !b[22]);
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      r.special = 1; r.result = 32'h7FC00000; r.invalid = 1;
    end else if (a_inf) begin
      r.special = 1; r.result = {s, 8'hFF, 23'h0};
    end else if (b_inf) begin
      r.special = 1; r.result = {s, 31'h0};
    end else if (b_zero) begin
      r.special = 1; r.result = {s, 8'hFF, 23'h0}; r.divzero = 1;
    end else if (a_zero) begin
      r.special = 1; r.result = {s, 31'h0};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 7))
      0: begin e = 8'h00; m = '0; end
      1: begin e = 8'hFF; m = '0; end
      2: begin e = 8'hFF; m[22] = 1'b1; end
      3: begin e = 8'hFF; m[22] = 1'b0; if (m == 0) m = 23'h1; end
      4: begin e = 8'h00; if (m == 0) m = 23'h1; end
      default: ;
    endcase
    return {s, e, m};
  endfunction

  // Scoreboard and sticky-flag model, evaluated mid-cycle.
  res_t got, held, e;
  bit   held_v, fi_m, fd_m, xi, xd;

  always @(negedge clk) begin
    got = {out_class_a, out_class_b, out_special, out_result, out_sign,
           out_man_a, out_man_b, out_exp_diff, out_invalid, out_divzero};
    if (!rst_n) begin
      q.delete();
      fi_m = 0; fd_m = 0; held_v = 0;
    end else begin
      chk("flag_invalid", 128'(flag_invalid), 128'(fi_m));
      chk("flag_divzero", 128'(flag_divzero), 128'(fd_m));
      chk("in_ready", 128'(in_ready), 128'((q.size() < 2) || out_ready));
      if (held_v) begin
        chk("stall_valid", 128'(out_valid), 128'(1'b1));
        chk("stall_hold", 128'(got), 128'(held));
      end
      xi = 0; xd = 0;
      if (out_valid && q.size() == 0) begin
        chk("out_without_pending", 128'(out_valid), 128'(1'b0));
      end else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("result", 128'(got), 128'(e));
        xi = e.invalid; xd = e.divzero;
      end
      fi_m = (clr_flags ? 1'b0 : fi_m) | xi;
      fd_m = (clr_flags ? 1'b0 : fd_m) | xd;
      held_v = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) q.push_back(model(in_a, in_b));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(tag, 128'(q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic latency_check(input string tag);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_cycle1_valid"}, 128'(out_valid), 128'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_cycle2_valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_class_a"}, 128'(out_class_a), 128'(5'b00001));
    chk({tag, "_class_b"}, 128'(out_class_b), 128'(5'b00001));
    chk({tag, "_special"}, 128'(out_special), 128'(1'b0));
    chk({tag, "_man_a"}, 128'(out_man_a), 128'(24'h800000));
    chk({tag, "_man_b"}, 128'(out_man_b), 128'(24'h800000));
    chk({tag, "_exp_diff"}, 128'(out_exp_diff), 128'(10'd126));
    @(posedge clk); #1;
  endtask

  task automatic pin_model();
    res_t m;
    m = model(32'h3F800000, 32'h40000000);
    chk("pin_norm_cls", 128'(m.cls_a), 128'(5'b00001));
    chk("pin_norm_special", 128'(m.special), 128'(1'b0));
    chk("pin_norm_man", 128'(m.man_a), 128'(24'h800000));
    chk("pin_norm_exp", 128'(m.exp_diff), 128'(10'd126));
    m = model(32'h3F800000, 32'h00000000);
    chk("pin_dz_result", 128'(m.result), 128'(32'h7F800000));
    chk("pin_dz_flag", 128'({m.invalid, m.divzero}), 128'(2'b01));
    m = model(32'h00000000, 32'h00000000);
    chk("pin_zz", 128'({m.result, m.invalid}), 128'({32'h7FC00000, 1'b1}));
    m = model(32'hFF800000, 32'h40000000);
    chk("pin_ninf", 128'({m.result, m.invalid, m.divzero}), 128'({32'hFF800000, 2'b00}));
    m = model(32'h7F800001, 32'h3F800000);
    chk("pin_snan", 128'({m.result, m.invalid}), 128'({32'h7FC00000, 1'b1}));
    m = model(32'h00000001, 32'h3F800000);
`ifdef SUBNORMAL_FLUSH_EN
    chk("pin_sub_cls", 128'(m.cls_a), 128'(5'b01000));
    chk("pin_sub_res", 128'({m.special, m.result}), 128'({1'b1, 32'h0}));
`else
    chk("pin_sub_cls", 128'(m.cls_a), 128'(5'b00010));
    chk("pin_sub_man", 128'(m.man_a), 128'(24'h000001));
    chk("pin_sub_exp", 128'({m.special, m.exp_diff}), 128'({1'b0, 10'd1}));
`endif
  endtask

  logic [31:0] dir_a [10] = '{32'h00000000, 32'hFF800000, 32'h7F800001, 32'h00000001, 32'h7FC00000,
                             32'h80000000, 32'h7F800000, 32'h40000000, 32'h00000000, 32'h80000001};
  logic [31:0] dir_b [10] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                             32'h7F800000, 32'h7F800000, 32'hFF800000, 32'hC0000000, 32'h00000000};

  initial begin
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; clr_flags = 1'b0;
    pin_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_result", 128'(out_result), 128'(32'h0));
    chk("rst_classes", 128'({out_class_a, out_class_b}), 128'(10'h0));
    chk("rst_exp_diff", 128'(out_exp_diff), 128'(10'h0));
    chk("rst_flags", 128'({flag_invalid, flag_divzero}), 128'(2'b00));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;

    out_ready = 1'b1;
    latency_check("lat");

    in_a = 32'h3F800000; in_b = 32'h00000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("dz_flag_before", 128'(flag_divzero), 128'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk("dz_out", 128'({out_valid, out_result, out_divzero}), 128'({1'b1, 32'h7F800000, 1'b1}));
    @(posedge clk);
    @(negedge clk);
    chk("dz_flag_set", 128'(flag_divzero), 128'(1'b1));
    repeat (3) @(negedge clk);
    chk("dz_flag_sticky", 128'(flag_divzero), 128'(1'b1));
    @(posedge clk); #1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    @(negedge clk);
    chk("dz_flag_cleared", 128'(flag_divzero), 128'(1'b0));
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) send(dir_a[i], dir_b[i]);
    wait_drain("directed_drain");

    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h40400000 + 32'(i); in_b = 32'h3F800000; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 128'(acc), 128'(2));
    @(negedge clk);
    chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_flags = 1'b0; out_ready = 1'b1;
    wait_drain("random_drain");

    send(32'h00000000, 32'h00000000);
    wait_drain("invalid_drain");
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000);
    send(32'h40000000, 32'h3F800000);
    @(negedge clk);
    chk("mr_inflight", 128'({out_valid, flag_invalid}), 128'(2'b11));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mr_flags", 128'({flag_invalid, flag_divzero}), 128'(2'b00));
    chk("mr_result", 128'(out_result), 128'(32'h0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    latency_check("post_mr");
    wait_drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
